// File: rtl/hf_reader_seq.sv
// ISO14443-A reader exchange sequencer: TX for a programmed number of bit periods, guard
// interval, then a listen window timing the first subcarrier detection or declaring a timeout.
module hf_reader_seq #(
    parameter int          CNT_W    = 16,
    parameter logic [2:0]  MOD_IDLE = 3'b000,
    parameter logic [2:0]  MOD_TX   = 3'b100,
    parameter logic [2:0]  MOD_RX   = 3'b011
) (
    input  logic             ck_1356meg,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       tx_len,
    input  logic [CNT_W-1:0] guard_len,
    input  logic [CNT_W-1:0] window_len,
    input  logic             bit_strobe,
    input  logic             curbit,
    output logic [2:0]       mod_type,
    output logic             busy,
    output logic             done,
    output logic             resp_seen,
    output logic             timeout,
    output logic [CNT_W-1:0] resp_latency
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_GUARD  = 3'd2,
        S_LISTEN = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_tx_len;
    logic [CNT_W-1:0] r_guard_len;
    logic [CNT_W-1:0] r_window_len;
    logic [7:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_guard_cnt;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [2:0]       r_mod_type;
    logic             r_busy;
    logic             r_done;
    logic             r_resp_seen;
    logic             r_timeout;
    logic [CNT_W-1:0] r_resp_latency;
    logic             w_tx_last;
    logic             w_guard_last;
    logic             w_win_last;
    logic             w_accept;

    function automatic logic [2:0] mode_of(input state_t s);
        logic [2:0] m;
        case (s)
            S_IDLE:                   m = MOD_IDLE;
            S_TX:                     m = MOD_TX;
            S_GUARD, S_LISTEN, S_DONE: m = MOD_RX;
            default:                  m = MOD_IDLE;
        endcase
        return m;
    endfunction

    // Terminal-count decodes and next-state selection; abort overrides every transition.
    always_comb begin
        w_next       = r_state;
        w_tx_last    = bit_strobe && ((r_bit_cnt + 8'd1) == r_tx_len);
        w_guard_last = (r_guard_len == CNT_ZERO) || (r_guard_cnt == (r_guard_len - CNT_ONE));
        w_win_last   = (r_lat_cnt == r_window_len);
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (tx_len != 8'd0) ? S_TX : S_GUARD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_TX: begin
                if (w_tx_last) w_next = S_GUARD;
                else           w_next = S_TX;
            end
            S_GUARD: begin
                if (w_guard_last) w_next = S_LISTEN;
                else              w_next = S_GUARD;
            end
            S_LISTEN: begin
                if (curbit || w_win_last) w_next = S_DONE;
                else                      w_next = S_LISTEN;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next   = S_IDLE;
            w_accept = 1'b0;
        end else begin
            w_accept = w_accept;
        end
    end

    // State, counters, latched lengths and registered outputs.
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_tx_len       <= 8'd0;
            r_guard_len    <= CNT_ZERO;
            r_window_len   <= CNT_ZERO;
            r_bit_cnt      <= 8'd0;
            r_guard_cnt    <= CNT_ZERO;
            r_lat_cnt      <= CNT_ZERO;
            r_mod_type     <= MOD_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_resp_seen    <= 1'b0;
            r_timeout      <= 1'b0;
            r_resp_latency <= CNT_ZERO;
        end else begin
            r_state    <= w_next;
            r_mod_type <= mode_of(w_next);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            // Counters run only while staying in their own state, so each restarts at 0 on entry.
            r_bit_cnt   <= (r_state == S_TX && w_next == S_TX) ? (r_bit_cnt + {7'd0, bit_strobe}) : 8'd0;
            r_guard_cnt <= (r_state == S_GUARD && w_next == S_GUARD) ? (r_guard_cnt + CNT_ONE) : CNT_ZERO;
            r_lat_cnt   <= (r_state == S_LISTEN && w_next == S_LISTEN) ? (r_lat_cnt + CNT_ONE) : CNT_ZERO;
            if (w_accept) begin
                r_tx_len       <= tx_len;
                r_guard_len    <= guard_len;
                r_window_len   <= window_len;
                r_resp_seen    <= 1'b0;
                r_timeout      <= 1'b0;
                r_resp_latency <= CNT_ZERO;
            end else if (r_state == S_LISTEN && !abort) begin
                if (curbit) begin
                    r_resp_latency <= r_lat_cnt;
                    r_resp_seen    <= 1'b1;
                end else if (w_win_last) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_timeout <= r_timeout;
                end
            end else begin
                r_resp_seen <= r_resp_seen;
            end
        end
    end

    assign mod_type     = r_mod_type;
    assign busy         = r_busy;
    assign done         = r_done;
    assign resp_seen    = r_resp_seen;
    assign timeout      = r_timeout;
    assign resp_latency = r_resp_latency;

endmodule

// File: tb/tb_hf_reader_seq.sv
// Directed bench for hf_reader_seq: one task per scenario with hand-computed expectations.
module tb_hf_reader_seq;

    logic        clk = 1'b0;
    logic        rst, start, abort, bit_strobe, curbit;
    logic [7:0]  tx_len;
    logic [15:0] guard_len, window_len;
    logic [2:0]  mod_type;
    logic        busy, done, resp_seen, timeout;
    logic [15:0] resp_latency;
    int          checks = 0;
    int          failures = 0;

    hf_reader_seq dut (
        .ck_1356meg(clk), .rst(rst), .start(start), .abort(abort),
        .tx_len(tx_len), .guard_len(guard_len), .window_len(window_len),
        .bit_strobe(bit_strobe), .curbit(curbit),
        .mod_type(mod_type), .busy(busy), .done(done), .resp_seen(resp_seen),
        .timeout(timeout), .resp_latency(resp_latency)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; tx_len = 8'd2;
        cyc(); cyc();
        start = 1'b0;
        checks++; if (mod_type !== 3'b000) begin failures++; $display("FAIL reset_mod got=%0h exp=0", mod_type); end
        checks++; if ({busy, done, resp_seen, timeout} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, resp_seen, timeout}); end
        checks++; if (resp_latency !== 16'd0) begin failures++; $display("FAIL reset_lat got=%0d exp=0", resp_latency); end
        rst = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_response();
        logic ok;
        tx_len = 8'd3; guard_len = 16'd4; window_len = 16'd100; curbit = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (mod_type !== 3'b100 || busy !== 1'b1) begin failures++; $display("FAIL resp_tx_entry got=%0h/%b exp=4/1", mod_type, busy); end
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bit_strobe = 1'b0;
            repeat (15) begin cyc(); if (mod_type !== 3'b100) ok = 1'b0; end
            bit_strobe = 1'b1; cyc(); bit_strobe = 1'b0;
            if (k < 2 && mod_type !== 3'b100) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL resp_tx_hold got=%b exp=1", ok); end
        checks++; if (mod_type !== 3'b011) begin failures++; $display("FAIL resp_guard_mod got=%0h exp=3", mod_type); end
        repeat (4) cyc();
        repeat (20) begin
            cyc();
            if (done !== 1'b0) ok = 1'b0;
        end
        curbit = 1'b1; cyc(); curbit = 1'b0;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL resp_early_done got=%b exp=1", ok); end
        checks++; if (done !== 1'b1 || mod_type !== 3'b011) begin failures++; $display("FAIL resp_done got=%b/%0h exp=1/3", done, mod_type); end
        checks++; if (resp_seen !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL resp_flags got=%b%b exp=10", resp_seen, timeout); end
        checks++; if (resp_latency !== 16'd20) begin failures++; $display("FAIL resp_latency got=%0d exp=20", resp_latency); end
        cyc();
        checks++; if ({done, busy, mod_type} !== 5'b00000) begin failures++; $display("FAIL resp_idle got=%b exp=00000", {done, busy, mod_type}); end
        checks++; if (resp_seen !== 1'b1 || resp_latency !== 16'd20) begin failures++; $display("FAIL resp_held got=%b/%0d exp=1/20", resp_seen, resp_latency); end
    endtask

    task automatic test_timeout();
        logic ok;
        ok = 1'b1;
        tx_len = 8'd1; guard_len = 16'd0; window_len = 16'd10; curbit = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        bit_strobe = 1'b1; cyc(); bit_strobe = 1'b0;
        checks++; if (mod_type !== 3'b011) begin failures++; $display("FAIL tmo_entry_strobe got=%0h exp=3", mod_type); end
        cyc();
        repeat (10) begin cyc(); if (done !== 1'b0) ok = 1'b0; end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tmo_early got=%b exp=1", ok); end
        cyc();
        checks++; if ({done, timeout, resp_seen} !== 3'b110) begin failures++; $display("FAIL tmo_result got=%b exp=110", {done, timeout, resp_seen}); end
        cyc();
    endtask

    task automatic test_late_response();
        tx_len = 8'd1; guard_len = 16'd2; window_len = 16'd5; curbit = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        bit_strobe = 1'b1; cyc(); bit_strobe = 1'b0;
        cyc(); cyc();
        curbit = 1'b0;
        repeat (5) cyc();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL late_wait got=%b%b exp=10", busy, done); end
        curbit = 1'b1; cyc(); curbit = 1'b0;
        checks++; if ({done, resp_seen, timeout} !== 3'b110) begin failures++; $display("FAIL late_flags got=%b exp=110", {done, resp_seen, timeout}); end
        checks++; if (resp_latency !== 16'd5) begin failures++; $display("FAIL late_latency got=%0d exp=5", resp_latency); end
        cyc();
    endtask

    task automatic test_start_ignored();
        logic ok;
        ok = 1'b1;
        tx_len = 8'd0; guard_len = 16'd1; window_len = 16'd8; curbit = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (mod_type !== 3'b011) begin failures++; $display("FAIL ign_skip_tx got=%0h exp=3", mod_type); end
        cyc();
        repeat (3) cyc();
        tx_len = 8'd5; guard_len = 16'd50; window_len = 16'd200;
        start = 1'b1; cyc(); start = 1'b0;
        if (mod_type !== 3'b011) ok = 1'b0;
        repeat (4) begin cyc(); if (done !== 1'b0) ok = 1'b0; end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ign_listen got=%b exp=1", ok); end
        cyc();
        checks++; if ({done, timeout} !== 2'b11) begin failures++; $display("FAIL ign_timeout got=%b exp=11", {done, timeout}); end
        cyc();
    endtask

    task automatic test_abort_and_reset();
        tx_len = 8'd0; guard_len = 16'd10; window_len = 16'd10;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        checks++; if ({mod_type, busy, done} !== 5'b00000) begin failures++; $display("FAIL abort_idle got=%b exp=00000", {mod_type, busy, done}); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL abort_cleared got=%b exp=0", timeout); end
        cyc();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_nodone got=%b%b exp=00", done, busy); end
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_over_start got=%b exp=0", busy); end
        tx_len = 8'd4;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++; if ({mod_type, busy, done, resp_seen, timeout} !== 7'd0 || resp_latency !== 16'd0) begin failures++; $display("FAIL rst_mid_tx got=%b/%0d exp=0/0", {mod_type, busy, done, resp_seen, timeout}, resp_latency); end
    endtask

    task automatic test_zero_window();
        tx_len = 8'd0; guard_len = 16'd2; window_len = 16'd0; curbit = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        checks++; if (done !== 1'b0 || mod_type !== 3'b011) begin failures++; $display("FAIL zw_listen got=%b/%0h exp=0/3", done, mod_type); end
        cyc();
        checks++; if ({done, timeout, resp_seen} !== 3'b110) begin failures++; $display("FAIL zw_timeout got=%b exp=110", {done, timeout, resp_seen}); end
        cyc();
        // Back-to-back exchange where the response coincides with the window limit.
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        curbit = 1'b1; cyc(); curbit = 1'b0;
        checks++; if ({done, resp_seen, timeout} !== 3'b110 || resp_latency !== 16'd0) begin failures++; $display("FAIL zw_curbit_wins got=%b/%0d exp=110/0", {done, resp_seen, timeout}, resp_latency); end
        cyc();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_strobe = 1'b0; curbit = 1'b0;
        tx_len = 8'd0; guard_len = 16'd0; window_len = 16'd0;
        test_reset();
        test_response();
        test_timeout();
        test_late_response();
        test_start_ignored();
        test_abort_and_reset();
        test_zero_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
